// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline constants: opcodes, instruction field slices and
// register-address width. No ports; imported by the front-end modules.
package mips_pipe_pkg;

  localparam int unsigned REG_AW = 5;

  // Opcodes the front end's neighbours care about
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LW  = 6'h23;

  // Instruction field slices
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned JIDX_W = 26;

  // Lowest PC bit kept from PC+4 when forming a jump address
  localparam int unsigned JREGION_LSB = JIDX_W + 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
// Ports: clk, reset (sync, active-low), inc (count one event), count (value).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_hazard_frontend.sv
// MIPS fetch/decode front end: IF PC, IF/ID register and a minimal ID/EX
// slice, with load-use stall, jump and branch redirect, imem wait handling
// and saturating stall/flush counters.
// Ports:
//   clk, reset (sync, active-low)
//   imem_addr/imem_instr/imem_valid   instruction memory interface
//   id_memread_v/id_jump_v            raw control decode of id_instr
//   ex_redirect/ex_target             taken branch from EX
//   id_instr/id_pc4/id_valid          IF/ID contents
//   stall/id_jump                     combinational hazard and gated jump
//   ex_memread/ex_rt/ex_valid         ID/EX slice
//   stall_cnt/flush_cnt               saturating performance counters
module if_id_hazard_frontend
  import mips_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              imem_valid,
  input  logic              id_memread_v,
  input  logic              id_jump_v,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  output logic [31:0]       id_instr,
  output logic [XLEN-1:0]   id_pc4,
  output logic              id_valid,
  output logic              stall,
  output logic              id_jump,
  output logic              ex_memread,
  output logic [REG_AW-1:0] ex_rt,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [XLEN-1:0]   id_pc4_q, id_pc4_d;
  logic              id_valid_q, id_valid_d;
  logic              ex_memread_q, ex_memread_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic              ex_valid_q, ex_valid_d;

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [XLEN-1:0]   jaddr;
  logic [XLEN-1:0]   pc_next_seq;
  logic              stall_w;
  logic              jump_w;
  logic              memread_w;
  logic              stall_inc;
  logic              flush_inc;

  assign id_rs       = id_instr_q[RS_MSB:RS_LSB];
  assign id_rt       = id_instr_q[RT_MSB:RT_LSB];
  assign jaddr       = {id_pc4_q[XLEN-1:JREGION_LSB], id_instr_q[JIDX_W-1:0], 2'b00};
  assign pc_next_seq = pc_q + XLEN'(PC_STEP);

  // Load-use hazard: a load in EX whose nonzero rt feeds the instruction in ID
  assign stall_w   = id_valid_q & ex_valid_q & ex_memread_q & (ex_rt_q != '0) &
                     ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
  assign jump_w    = id_jump_v & id_valid_q & ~stall_w;
  assign memread_w = id_memread_v & id_valid_q & ~stall_w;

  // A redirect only counts a flush when it kills a real instruction
  assign stall_inc = stall_w & ~ex_redirect;
  assign flush_inc = ex_redirect ? id_valid_q : jump_w;

  // Next-state selection, first matching event wins
  always_comb begin
    pc_d         = pc_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;
    id_valid_d   = id_valid_q;
    ex_memread_d = memread_w;
    ex_rt_d      = id_valid_q ? id_rt : '0;
    ex_valid_d   = id_valid_q;

    if (ex_redirect) begin
      pc_d         = ex_target;
      id_instr_d   = '0;
      id_pc4_d     = '0;
      id_valid_d   = 1'b0;
      ex_memread_d = 1'b0;
      ex_rt_d      = '0;
      ex_valid_d   = 1'b0;
    end else if (stall_w) begin
      ex_memread_d = 1'b0;
      ex_rt_d      = '0;
      ex_valid_d   = 1'b0;
    end else if (jump_w) begin
      pc_d       = jaddr;
      id_instr_d = '0;
      id_pc4_d   = '0;
      id_valid_d = 1'b0;
    end else if (!imem_valid) begin
      id_instr_d = '0;
      id_pc4_d   = '0;
      id_valid_d = 1'b0;
    end else begin
      pc_d       = pc_next_seq;
      id_instr_d = imem_instr;
      id_pc4_d   = pc_next_seq;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      id_instr_q   <= '0;
      id_pc4_q     <= '0;
      id_valid_q   <= 1'b0;
      ex_memread_q <= 1'b0;
      ex_rt_q      <= '0;
      ex_valid_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
      id_valid_q   <= id_valid_d;
      ex_memread_q <= ex_memread_d;
      ex_rt_q      <= ex_rt_d;
      ex_valid_q   <= ex_valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign imem_addr  = pc_q;
  assign id_instr   = id_instr_q;
  assign id_pc4     = id_pc4_q;
  assign id_valid   = id_valid_q;
  assign stall      = stall_w;
  assign id_jump    = jump_w;
  assign ex_memread = ex_memread_q;
  assign ex_rt      = ex_rt_q;
  assign ex_valid   = ex_valid_q;

endmodule

// File: tb/tb_if_id_hazard_frontend.sv
// Randomized bench for if_id_hazard_frontend against a pipeline model that
// tracks the fetch PC and the two stage contents as plain variables.
module tb_if_id_hazard_frontend;
  import mips_pipe_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  imem_addr;
  logic [31:0]      imem_instr;
  logic             imem_valid;
  logic             id_memread_v;
  logic             id_jump_v;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_target;
  logic [31:0]      id_instr;
  logic [XLEN-1:0]  id_pc4;
  logic             id_valid;
  logic             stall;
  logic             id_jump;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             ex_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  if_id_hazard_frontend #(
    .XLEN(XLEN), .RESET_PC(32'h0), .PC_STEP(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_valid(imem_valid), .id_memread_v(id_memread_v), .id_jump_v(id_jump_v),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_valid(id_valid), .stall(stall), .id_jump(id_jump),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_valid(ex_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what each pipeline stage should hold
  logic [31:0] m_pc, m_id_instr, m_id_pc4;
  bit          m_id_valid, m_ex_mr, m_ex_valid;
  logic [4:0]  m_ex_rt;
  int          m_scnt, m_fcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_id_instr = '0; m_id_pc4 = '0; m_id_valid = 0;
    m_ex_mr = 0; m_ex_rt = '0; m_ex_valid = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // One clock: drive inputs, check outputs, then advance the model
  task automatic cycle(input bit rst, input bit iv, input logic [31:0] instr,
                       input bit redir, input logic [31:0] tgt);
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    bit          is_load, is_jump, hz, jmp, mr_drv, j_drv;
    logic [31:0] nxt_pc;
    @(negedge clk);
    op = m_id_instr[31:26];
    rs = m_id_instr[25:21];
    rt = m_id_instr[20:16];
    is_load = m_id_valid && (op == OP_LW);
    is_jump = m_id_valid && (op == OP_J || op == OP_JAL);
    // Raw control may be junk on a bubble; the block must ignore it
    mr_drv = is_load || (!m_id_valid && $urandom_range(0, 1) == 1);
    j_drv  = is_jump || (!m_id_valid && $urandom_range(0, 1) == 1);
    reset = rst; imem_valid = iv; imem_instr = instr;
    ex_redirect = redir; ex_target = tgt;
    id_memread_v = mr_drv; id_jump_v = j_drv;

    // A load in EX blocks the next instruction if it reads the loaded reg
    hz  = m_ex_valid && m_ex_mr && m_ex_rt != 0 && m_id_valid && (m_ex_rt == rs || m_ex_rt == rt);
    jmp = is_jump && !hz;
    #1;
    check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("id_instr", 64'(id_instr), 64'(m_id_instr));
    check("id_pc4", 64'(id_pc4), 64'(m_id_pc4));
    check("id_valid", 64'(id_valid), 64'(m_id_valid));
    check("stall", 64'(stall), 64'(hz));
    check("id_jump", 64'(id_jump), 64'(jmp));
    check("ex_memread", 64'(ex_memread), 64'(m_ex_mr));
    check("ex_rt", 64'(ex_rt), 64'(m_ex_rt));
    check("ex_valid", 64'(ex_valid), 64'(m_ex_valid));
    check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
    check("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (redir) begin
      if (m_id_valid) m_fcnt = sat_inc(m_fcnt);
      m_pc = tgt;
      m_id_instr = '0; m_id_pc4 = '0; m_id_valid = 0;
      m_ex_mr = 0; m_ex_rt = '0; m_ex_valid = 0;
    end else if (hz) begin
      m_scnt = sat_inc(m_scnt);
      m_ex_mr = 0; m_ex_rt = '0; m_ex_valid = 0;
    end else begin
      // Instruction in ID moves to EX in every remaining case
      m_ex_mr = is_load; m_ex_rt = m_id_valid ? rt : 5'd0; m_ex_valid = m_id_valid;
      if (jmp) begin
        m_fcnt = sat_inc(m_fcnt);
        m_pc = (m_id_pc4 & 32'hF000_0000) | {4'h0, m_id_instr[25:0], 2'b00};
        m_id_instr = '0; m_id_pc4 = '0; m_id_valid = 0;
      end else if (!iv) begin
        m_id_instr = '0; m_id_pc4 = '0; m_id_valid = 0;
      end else begin
        nxt_pc = m_pc + 32'd4;
        m_id_instr = instr; m_id_pc4 = nxt_pc; m_id_valid = 1;
        m_pc = nxt_pc;
      end
    end
  endtask

  // Random instruction mix biased toward loads and dependent R-types on $0..$3
  function automatic logic [31:0] gen_instr();
    int         k  = $urandom_range(0, 9);
    logic [4:0] rs = 5'($urandom_range(0, 3));
    logic [4:0] rt = 5'($urandom_range(0, 3));
    logic [31:0] w;
    case (k)
      0, 1, 2: w = {OP_LW, rs, rt, 16'($urandom)};
      3, 4, 5: w = {6'h00, rs, rt, 5'd3, 5'd0, 6'h20};
      6:       w = {($urandom_range(0, 1) == 1) ? OP_JAL : OP_J, 26'($urandom)};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] tgt;
    reset = 1'b0; imem_valid = 1'b1; imem_instr = '0; ex_redirect = 1'b0;
    ex_target = '0; id_memread_v = 1'b0; id_jump_v = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held, then straight-line fetch
    cycle(0, 1, 32'h8C22_0000, 0, 0);
    cycle(0, 1, 32'h8C22_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // lw $2 then dependent add: one stall
    cycle(1, 1, 32'h8C22_0000, 0, 0);
    cycle(1, 1, 32'h0044_1820, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // lw $0 then reader of $0: no stall
    cycle(1, 1, 32'h8C20_0000, 0, 0);
    cycle(1, 1, 32'h0000_1820, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // j 0x100
    cycle(1, 1, 32'h0800_0040, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // lw $5 then j with rs = 5: stall first, jump after
    cycle(1, 1, 32'h8C25_0000, 0, 0);
    cycle(1, 1, 32'h08A0_0080, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // Redirect coinciding with a stall and an imem wait
    cycle(1, 1, 32'h8C22_0000, 0, 0);
    cycle(1, 1, 32'h0044_1820, 0, 0);
    cycle(1, 0, 32'h0000_0000, 1, 32'h0000_0400);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // Three imem wait cycles
    cycle(1, 0, 32'h0000_0000, 0, 0);
    cycle(1, 0, 32'h0000_0000, 0, 0);
    cycle(1, 0, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // PC wrap from the top of the address space
    cycle(1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);
    // Saturate stall_cnt with repeated load-use pairs
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 32'h8C22_0000, 0, 0);
      cycle(1, 1, 32'h0044_1820, 0, 0);
      cycle(1, 1, 32'h0000_0000, 0, 0);
    end
    // Reset in the middle of a stall
    cycle(1, 1, 32'h8C22_0000, 0, 0);
    cycle(1, 1, 32'h0044_1820, 0, 0);
    cycle(0, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0000_0000, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 149) != 0, $urandom_range(0, 5) != 0, gen_instr(),
            $urandom_range(0, 19) == 0, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
